id_ex_fwd_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage pipelined RV32I core, combined with the EX-stage operand forwarding muxes.
- Directly feeds the ALU: o_op_a, o_op_b and o_alu_op connect to i_op_a, i_op_b and i_alu_op.
- Detects load-use hazards, stalls upstream and inserts bubbles.
- Honours flushes from branch resolution.

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/id_ex_fwd_stage_fwd_mux.sv | 40 ++++
 rtl/id_ex_fwd_stage.sv | 140 ++++++++++++++
 tb/tb_id_ex_fwd_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: widths, ALU op codes, forwarding
// source encodings and the ID/EX pipeline register layout.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_SRL  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_XOR  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_AND  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // An all-zero value of this struct is a bubble: the ALU computes 0 + 0.
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [3:0]        alu_op;
    logic              opa_sel;
    logic              opb_sel;
    logic              rd_wren;
    logic              mem_rden;
  } id_ex_t;

endpackage

// File: rtl/id_ex_fwd_stage_fwd_mux.sv
// Single-operand forwarding: picks the youngest in-flight producer of a
// source register, with EX/MEM ahead of MEM/WB; x0 is never forwarded.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   reg_data,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_rd_wren,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_rd_wren,
  input  logic [XLEN-1:0]   wb_data,
  output logic [1:0]        sel,
  output logic [XLEN-1:0]   data
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_rd_wren && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr);
  assign wb_hit  = wb_rd_wren  && (wb_rd_addr  != '0) && (wb_rd_addr  == rs_addr);

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    sel  = FWD_REG;
    data = reg_data;
    if (mem_hit) begin
      sel  = FWD_MEM;
      data = mem_data;
    end else if (wb_hit) begin
      sel  = FWD_WB;
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use stall
// detection, bubble insertion and a saturating stall-cycle counter.
module id_ex_fwd_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [XLEN-1:0]   i_id_pc,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic [REG_AW-1:0] i_id_rd_addr,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [XLEN-1:0]   i_id_rs1_data,
  input  logic [XLEN-1:0]   i_id_rs2_data,
  input  logic [XLEN-1:0]   i_id_imm,
  input  logic [3:0]        i_id_alu_op,
  input  logic              i_id_opa_sel,
  input  logic              i_id_opb_sel,
  input  logic              i_id_rd_wren,
  input  logic              i_id_mem_rden,
  input  logic              i_flush,
  input  logic [REG_AW-1:0] i_mem_rd_addr,
  input  logic              i_mem_rd_wren,
  input  logic [XLEN-1:0]   i_mem_fwd_data,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  input  logic              i_wb_rd_wren,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic              o_stall,
  output logic [XLEN-1:0]   o_op_a,
  output logic [XLEN-1:0]   o_op_b,
  output logic [3:0]        o_alu_op,
  output logic              o_ex_valid,
  output logic [REG_AW-1:0] o_ex_rd_addr,
  output logic              o_ex_rd_wren,
  output logic              o_ex_mem_rden,
  output logic [XLEN-1:0]   o_ex_pc,
  output logic [XLEN-1:0]   o_ex_store_data,
  output logic [1:0]        o_fwd_a_sel,
  output logic [1:0]        o_fwd_b_sel,
  output logic [31:0]       o_stall_cnt
);

  id_ex_t      ex_q;
  id_ex_t      id_cap;
  logic [31:0] stall_cnt_q;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic        wb_byp_rs1;
  logic        wb_byp_rs2;
  logic        load_use;

  // The regfile write in WB lands in the same edge as this capture, so the
  // read data from ID is stale; take the value being written instead.
  assign wb_byp_rs1 = i_wb_rd_wren && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_id_rs1_addr);
  assign wb_byp_rs2 = i_wb_rd_wren && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_id_rs2_addr);

  always_comb begin
    id_cap          = '0;
    id_cap.valid    = i_id_valid;
    id_cap.pc       = i_id_pc;
    id_cap.rs1_addr = i_id_rs1_addr;
    id_cap.rs2_addr = i_id_rs2_addr;
    id_cap.rd_addr  = i_id_rd_addr;
    id_cap.rs1_data = wb_byp_rs1 ? i_wb_data : i_id_rs1_data;
    id_cap.rs2_data = wb_byp_rs2 ? i_wb_data : i_id_rs2_data;
    id_cap.imm      = i_id_imm;
    id_cap.alu_op   = i_id_alu_op;
    id_cap.opa_sel  = i_id_opa_sel;
    id_cap.opb_sel  = i_id_opb_sel;
    id_cap.rd_wren  = i_id_rd_wren;
    id_cap.mem_rden = i_id_mem_rden;
  end

  // A flush wins over the hazard: the dependent instruction is being killed anyway.
  assign load_use = ex_q.valid && ex_q.mem_rden && (ex_q.rd_addr != '0) && i_id_valid
                 && ((i_id_rs1_used && (i_id_rs1_addr == ex_q.rd_addr))
                  || (i_id_rs2_used && (i_id_rs2_addr == ex_q.rd_addr)))
                 && !i_flush;
  assign o_stall  = load_use;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (i_flush || load_use || !i_id_valid) begin
        ex_q <= '0;
      end else begin
        ex_q <= id_cap;
      end
      if (load_use && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
    .rs_addr     (ex_q.rs1_addr),
    .reg_data    (ex_q.rs1_data),
    .mem_rd_addr (i_mem_rd_addr),
    .mem_rd_wren (i_mem_rd_wren),
    .mem_data    (i_mem_fwd_data),
    .wb_rd_addr  (i_wb_rd_addr),
    .wb_rd_wren  (i_wb_rd_wren),
    .wb_data     (i_wb_data),
    .sel         (o_fwd_a_sel),
    .data        (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
    .rs_addr     (ex_q.rs2_addr),
    .reg_data    (ex_q.rs2_data),
    .mem_rd_addr (i_mem_rd_addr),
    .mem_rd_wren (i_mem_rd_wren),
    .mem_data    (i_mem_fwd_data),
    .wb_rd_addr  (i_wb_rd_addr),
    .wb_rd_wren  (i_wb_rd_wren),
    .wb_data     (i_wb_data),
    .sel         (o_fwd_b_sel),
    .data        (fwd_rs2)
  );

  assign o_op_a          = ex_q.opa_sel ? ex_q.pc  : fwd_rs1;
  assign o_op_b          = ex_q.opb_sel ? ex_q.imm : fwd_rs2;
  assign o_ex_store_data = fwd_rs2;
  assign o_alu_op        = ex_q.alu_op;
  assign o_ex_valid      = ex_q.valid;
  assign o_ex_rd_addr    = ex_q.rd_addr;
  assign o_ex_rd_wren    = ex_q.rd_wren;
  assign o_ex_mem_rden   = ex_q.mem_rden;
  assign o_ex_pc         = ex_q.pc;
  assign o_stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Bench for id_ex_fwd_stage: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the stage.
module tb_id_ex_fwd_stage;

  logic        i_clk;
  logic        i_reset;
  logic        i_id_valid;
  logic [31:0] i_id_pc;
  logic [4:0]  i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr;
  logic        i_id_rs1_used, i_id_rs2_used;
  logic [31:0] i_id_rs1_data, i_id_rs2_data, i_id_imm;
  logic [3:0]  i_id_alu_op;
  logic        i_id_opa_sel, i_id_opb_sel, i_id_rd_wren, i_id_mem_rden;
  logic        i_flush;
  logic [4:0]  i_mem_rd_addr;
  logic        i_mem_rd_wren;
  logic [31:0] i_mem_fwd_data;
  logic [4:0]  i_wb_rd_addr;
  logic        i_wb_rd_wren;
  logic [31:0] i_wb_data;
  logic        o_stall;
  logic [31:0] o_op_a, o_op_b;
  logic [3:0]  o_alu_op;
  logic        o_ex_valid;
  logic [4:0]  o_ex_rd_addr;
  logic        o_ex_rd_wren, o_ex_mem_rden;
  logic [31:0] o_ex_pc, o_ex_store_data;
  logic [1:0]  o_fwd_a_sel, o_fwd_b_sel;
  logic [31:0] o_stall_cnt;

  int checks = 0;
  int failures = 0;

  id_ex_fwd_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr), .i_id_rd_addr(i_id_rd_addr),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
    .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data), .i_id_imm(i_id_imm),
    .i_id_alu_op(i_id_alu_op), .i_id_opa_sel(i_id_opa_sel), .i_id_opb_sel(i_id_opb_sel),
    .i_id_rd_wren(i_id_rd_wren), .i_id_mem_rden(i_id_mem_rden), .i_flush(i_flush),
    .i_mem_rd_addr(i_mem_rd_addr), .i_mem_rd_wren(i_mem_rd_wren), .i_mem_fwd_data(i_mem_fwd_data),
    .i_wb_rd_addr(i_wb_rd_addr), .i_wb_rd_wren(i_wb_rd_wren), .i_wb_data(i_wb_data),
    .o_stall(o_stall), .o_op_a(o_op_a), .o_op_b(o_op_b), .o_alu_op(o_alu_op),
    .o_ex_valid(o_ex_valid), .o_ex_rd_addr(o_ex_rd_addr), .o_ex_rd_wren(o_ex_rd_wren),
    .o_ex_mem_rden(o_ex_mem_rden), .o_ex_pc(o_ex_pc), .o_ex_store_data(o_ex_store_data),
    .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel), .o_stall_cnt(o_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_id_valid = 0; i_id_pc = '0; i_id_rs1_addr = '0; i_id_rs2_addr = '0; i_id_rd_addr = '0;
    i_id_rs1_used = 0; i_id_rs2_used = 0; i_id_rs1_data = '0; i_id_rs2_data = '0;
    i_id_imm = '0; i_id_alu_op = '0; i_id_opa_sel = 0; i_id_opb_sel = 0;
    i_id_rd_wren = 0; i_id_mem_rden = 0; i_flush = 0;
    i_mem_rd_addr = '0; i_mem_rd_wren = 0; i_mem_fwd_data = '0;
    i_wb_rd_addr = '0; i_wb_rd_wren = 0; i_wb_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 0;
    tick();
    tick();
    i_reset = 1;
  endtask

  // Present "lw x7" in ID and clock it into EX.
  task automatic load_x7();
    idle_inputs();
    i_id_valid = 1; i_id_pc = 32'h100; i_id_rd_addr = 5'd7;
    i_id_rd_wren = 1; i_id_mem_rden = 1; i_id_rs1_addr = 5'd2; i_id_rs1_used = 1;
    i_id_opb_sel = 1; i_id_imm = 32'd8;
    tick();
  endtask

  // Present "add x8, x7, x1" in ID (not clocked).
  task automatic present_add(input logic rs1_used);
    idle_inputs();
    i_id_valid = 1; i_id_pc = 32'h104; i_id_rs1_addr = 5'd7; i_id_rs2_addr = 5'd1;
    i_id_rd_addr = 5'd8; i_id_rs1_used = rs1_used; i_id_rs2_used = 1;
    i_id_rs1_data = 32'd70; i_id_rs2_data = 32'd11; i_id_rd_wren = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_id_valid = 1; i_id_pc = 32'hCAFE_0000; i_id_rd_wren = 1; i_id_mem_rden = 1;
    i_id_alu_op = 4'hA; i_id_opa_sel = 1; i_id_opb_sel = 1; i_id_imm = 32'h55;
    i_reset = 0;
    tick();
    tick();
    checks++; if (o_ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_ex_valid); end
    checks++; if (o_op_a !== 32'd0) begin failures++; $display("FAIL reset_op_a got=%h exp=0", o_op_a); end
    checks++; if (o_op_b !== 32'd0) begin failures++; $display("FAIL reset_op_b got=%h exp=0", o_op_b); end
    checks++; if (o_alu_op !== 4'b0000) begin failures++; $display("FAIL reset_alu_op got=%b exp=0000", o_alu_op); end
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
    checks++; if (o_stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", o_stall_cnt); end
    checks++; if ({o_ex_rd_wren, o_ex_mem_rden} !== 2'b00) begin failures++; $display("FAIL reset_ctl got=%b exp=00", {o_ex_rd_wren, o_ex_mem_rden}); end
    i_reset = 1;
    idle_inputs();
  endtask

  task automatic test_fwd_priority();
    idle_inputs();
    i_id_valid = 1; i_id_rs1_addr = 5'd5; i_id_rs1_used = 1; i_id_rs1_data = 32'd10;
    tick();
    idle_inputs();
    i_mem_rd_addr = 5'd5; i_mem_rd_wren = 1; i_mem_fwd_data = 32'h1234;
    i_wb_rd_addr = 5'd5; i_wb_rd_wren = 1; i_wb_data = 32'h9999;
    #1;
    checks++; if (o_op_a !== 32'h1234 || o_fwd_a_sel !== 2'b01) begin failures++; $display("FAIL fwd_mem got=%h/%b exp=1234/01", o_op_a, o_fwd_a_sel); end
    i_mem_rd_wren = 0;
    #1;
    checks++; if (o_op_a !== 32'h9999 || o_fwd_a_sel !== 2'b10) begin failures++; $display("FAIL fwd_wb got=%h/%b exp=9999/10", o_op_a, o_fwd_a_sel); end
    i_wb_rd_wren = 0;
    #1;
    checks++; if (o_op_a !== 32'd10 || o_fwd_a_sel !== 2'b00) begin failures++; $display("FAIL fwd_reg got=%h/%b exp=a/00", o_op_a, o_fwd_a_sel); end
  endtask

  task automatic test_x0();
    idle_inputs();
    i_id_valid = 1; i_id_rs1_addr = 5'd0; i_id_rs1_used = 1;
    tick();
    idle_inputs();
    i_mem_rd_addr = 5'd0; i_mem_rd_wren = 1; i_mem_fwd_data = 32'hFFFF;
    i_wb_rd_addr = 5'd0; i_wb_rd_wren = 1; i_wb_data = 32'h7777;
    #1;
    checks++; if (o_op_a !== 32'd0 || o_fwd_a_sel !== 2'b00) begin failures++; $display("FAIL x0_fwd got=%h/%b exp=0/00", o_op_a, o_fwd_a_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    load_x7();
    present_add(1'b1);
    checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", o_stall); end
    tick();
    checks++; if (o_ex_valid !== 1'b0 || o_stall_cnt !== 32'd1) begin failures++; $display("FAIL lu_bubble got=%b/%0d exp=0/1", o_ex_valid, o_stall_cnt); end
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", o_stall); end
    tick();
    checks++; if (o_ex_valid !== 1'b1 || o_ex_rd_addr !== 5'd8 || o_ex_pc !== 32'h104) begin failures++; $display("FAIL lu_capture got=%b/%0d/%h exp=1/8/104", o_ex_valid, o_ex_rd_addr, o_ex_pc); end
    checks++; if (o_stall_cnt !== 32'd1) begin failures++; $display("FAIL lu_cnt_hold got=%0d exp=1", o_stall_cnt); end
    // rs1 field matches but is not read: no hazard.
    do_reset();
    load_x7();
    present_add(1'b0);
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL lu_unused got=%b exp=0", o_stall); end
    tick();
    checks++; if (o_ex_valid !== 1'b1 || o_stall_cnt !== 32'd0) begin failures++; $display("FAIL lu_unused_cap got=%b/%0d exp=1/0", o_ex_valid, o_stall_cnt); end
  endtask

  task automatic test_flush_hazard();
    do_reset();
    load_x7();
    present_add(1'b1);
    i_flush = 1;
    #1;
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL fl_stall got=%b exp=0", o_stall); end
    tick();
    checks++; if (o_ex_valid !== 1'b0 || o_stall_cnt !== 32'd0) begin failures++; $display("FAIL fl_bubble got=%b/%0d exp=0/0", o_ex_valid, o_stall_cnt); end
    checks++; if (o_op_a !== 32'd0 || o_op_b !== 32'd0 || o_ex_rd_wren !== 1'b0) begin failures++; $display("FAIL fl_zero got=%h/%h/%b exp=0/0/0", o_op_a, o_op_b, o_ex_rd_wren); end
  endtask

  task automatic test_capture_bypass();
    idle_inputs();
    i_id_valid = 1; i_id_rs2_addr = 5'd3; i_id_rs2_used = 1; i_id_rs2_data = 32'd0;
    i_wb_rd_addr = 5'd3; i_wb_rd_wren = 1; i_wb_data = 32'hDEAD;
    tick();
    i_wb_rd_wren = 0; i_id_valid = 0;
    #1;
    checks++; if (o_op_b !== 32'hDEAD || o_fwd_b_sel !== 2'b00) begin failures++; $display("FAIL byp_op_b got=%h/%b exp=dead/00", o_op_b, o_fwd_b_sel); end
    i_id_valid = 1; i_wb_rd_wren = 1; i_id_opb_sel = 1; i_id_imm = 32'hFFFF_FFFC; i_id_alu_op = 4'b0001;
    tick();
    i_wb_rd_wren = 0; i_id_valid = 0;
    #1;
    checks++; if (o_op_b !== 32'hFFFF_FFFC || o_alu_op !== 4'b0001) begin failures++; $display("FAIL byp_imm got=%h/%b exp=fffffffc/0001", o_op_b, o_alu_op); end
    checks++; if (o_ex_store_data !== 32'hDEAD) begin failures++; $display("FAIL byp_store got=%h exp=dead", o_ex_store_data); end
  endtask

  // ---------------- behavioural model for the random run ----------------
  typedef struct {
    bit valid; logic [31:0] pc; logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm; logic [3:0] op; bit asel, bsel, wren, rden;
  } tb_ex_t;

  tb_ex_t      m;
  logic [31:0] m_cnt;

  function automatic logic [33:0] ref_fwd(input logic [4:0] a, input logic [31:0] v);
    if (i_mem_rd_wren && i_mem_rd_addr != 0 && i_mem_rd_addr == a) return {2'b01, i_mem_fwd_data};
    if (i_wb_rd_wren && i_wb_rd_addr != 0 && i_wb_rd_addr == a) return {2'b10, i_wb_data};
    return {2'b00, v};
  endfunction

  task automatic test_random();
    logic [33:0] fa, fb;
    logic [31:0] exp_a, exp_b;
    bit          exp_stall;
    do_reset();
    m = '{default: '0};
    m_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      i_reset        = ($urandom_range(0, 39) != 0);
      i_id_valid     = ($urandom_range(0, 5) != 0);
      i_id_pc        = $urandom;
      i_id_rs1_addr  = 5'($urandom_range(0, 3));
      i_id_rs2_addr  = 5'($urandom_range(0, 3));
      i_id_rd_addr   = 5'($urandom_range(0, 3));
      i_id_rs1_used  = 1'($urandom);
      i_id_rs2_used  = 1'($urandom);
      i_id_rs1_data  = $urandom;
      i_id_rs2_data  = $urandom;
      i_id_imm       = $urandom;
      i_id_alu_op    = 4'($urandom);
      i_id_opa_sel   = 1'($urandom);
      i_id_opb_sel   = 1'($urandom);
      i_id_rd_wren   = 1'($urandom);
      i_id_mem_rden  = ($urandom_range(0, 2) == 0);
      i_flush        = ($urandom_range(0, 9) == 0);
      i_mem_rd_addr  = 5'($urandom_range(0, 3));
      i_mem_rd_wren  = 1'($urandom);
      i_mem_fwd_data = $urandom;
      i_wb_rd_addr   = 5'($urandom_range(0, 3));
      i_wb_rd_wren   = 1'($urandom);
      i_wb_data      = $urandom;
      #1;
      fa = ref_fwd(m.rs1, m.d1);
      fb = ref_fwd(m.rs2, m.d2);
      exp_a = m.asel ? m.pc : fa[31:0];
      exp_b = m.bsel ? m.imm : fb[31:0];
      exp_stall = m.valid && m.rden && m.rd != 0 && i_id_valid &&
                  ((i_id_rs1_used && i_id_rs1_addr == m.rd) || (i_id_rs2_used && i_id_rs2_addr == m.rd)) &&
                  !i_flush;
      checks++;
      if ({o_op_a, o_op_b, o_ex_store_data, o_fwd_a_sel, o_fwd_b_sel} !== {exp_a, exp_b, fb[31:0], fa[33:32], fb[33:32]}) begin
        failures++;
        $display("FAIL rand_operands cyc=%0d got=%h/%h/%h/%b/%b exp=%h/%h/%h/%b/%b", cyc,
                 o_op_a, o_op_b, o_ex_store_data, o_fwd_a_sel, o_fwd_b_sel,
                 exp_a, exp_b, fb[31:0], fa[33:32], fb[33:32]);
      end
      checks++;
      if ({o_ex_valid, o_ex_rd_addr, o_ex_rd_wren, o_ex_mem_rden, o_ex_pc, o_alu_op} !==
          {m.valid, m.rd, m.wren, m.rden, m.pc, m.op}) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d got=%b/%0d/%b/%b/%h/%b exp=%b/%0d/%b/%b/%h/%b", cyc,
                 o_ex_valid, o_ex_rd_addr, o_ex_rd_wren, o_ex_mem_rden, o_ex_pc, o_alu_op,
                 m.valid, m.rd, m.wren, m.rden, m.pc, m.op);
      end
      checks++;
      if (o_stall !== exp_stall || o_stall_cnt !== m_cnt) begin
        failures++;
        $display("FAIL rand_stall cyc=%0d got=%b/%0d exp=%b/%0d", cyc, o_stall, o_stall_cnt, exp_stall, m_cnt);
      end
      if (!i_reset) begin
        m = '{default: '0};
        m_cnt = 0;
      end else if (i_flush || exp_stall || !i_id_valid) begin
        if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m = '{default: '0};
      end else begin
        m.valid = 1; m.pc = i_id_pc; m.rs1 = i_id_rs1_addr; m.rs2 = i_id_rs2_addr; m.rd = i_id_rd_addr;
        m.d1 = (i_wb_rd_wren && i_wb_rd_addr != 0 && i_wb_rd_addr == i_id_rs1_addr) ? i_wb_data : i_id_rs1_data;
        m.d2 = (i_wb_rd_wren && i_wb_rd_addr != 0 && i_wb_rd_addr == i_id_rs2_addr) ? i_wb_data : i_id_rs2_data;
        m.imm = i_id_imm; m.op = i_id_alu_op; m.asel = i_id_opa_sel; m.bsel = i_id_opb_sel;
        m.wren = i_id_rd_wren; m.rden = i_id_mem_rden;
      end
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    i_reset = 1;
    idle_inputs();
    test_reset();
    test_fwd_priority();
    test_x0();
    test_load_use();
    test_flush_hazard();
    test_capture_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
